// File: rtl/scalar_dcache_pkg.sv
// Shared types and address-split helpers for the scalar data cache.
// Tags are held zero-extended to the widest case (SETS=2), so one frame type serves every SETS.
package scalar_dcache_pkg;

    localparam int unsigned TAG_MAX_W = 29;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL
    } dcache_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          data;
    } dcache_frame_t;

    typedef struct packed {
        logic valid;
        logic dirty;
        logic tag;
        logic data;
    } dcache_wmask_t;

    // Frame index of a byte address.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned idx_w);
        return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag of a byte address (bits above the index).
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned idx_w);
        return addr >> (idx_w + 2);
    endfunction

    // Rebuild the word-aligned byte address held by a frame.
    function automatic logic [31:0] frame_addr(input logic [TAG_MAX_W-1:0] tag,
                                               input logic [31:0] idx,
                                               input int unsigned idx_w);
        return (32'(tag) << (idx_w + 2)) | (idx << 2);
    endfunction

endpackage

// File: rtl/scalar_dcache_array.sv
// Frame storage for the scalar data cache: SETS frames, combinational read,
// one masked write port. Only valid/dirty are reset; tag/data are don't-care while invalid.
module scalar_dcache_array
    import scalar_dcache_pkg::*;
#(
    parameter int unsigned SETS  = 16,
    parameter int unsigned IDX_W = $clog2(SETS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_raddr,
    output dcache_frame_t    o_rframe,
    input  logic [IDX_W-1:0] i_waddr,
    input  dcache_wmask_t    i_wmask,
    input  dcache_frame_t    i_wframe
);

    dcache_frame_t r_mem [SETS];

    assign o_rframe = r_mem[i_raddr];

    // Clear state bits on reset, otherwise apply the per-field write mask.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < SETS; i++) begin
                r_mem[i].valid <= 1'b0;
                r_mem[i].dirty <= 1'b0;
            end
        end else begin
            if (i_wmask.valid) r_mem[i_waddr].valid <= i_wframe.valid;
            if (i_wmask.dirty) r_mem[i_waddr].dirty <= i_wframe.dirty;
            if (i_wmask.tag)   r_mem[i_waddr].tag   <= i_wframe.tag;
            if (i_wmask.data)  r_mem[i_waddr].data  <= i_wframe.data;
        end
    end

endmodule

// File: rtl/scalar_dcache.sv
// Direct-mapped, write-back, one-word-block data cache for the scalar LS unit.
// Misses go IDLE -> [WB] -> FILL -> IDLE and the held request then hits on replay.
// Optional: SCALAR_DCACHE_STATS_EN adds hit_count / miss_count outputs.
module scalar_dcache
    import scalar_dcache_pkg::*;
#(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmem_in,
    output logic        dhit_in,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
`ifdef SCALAR_DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);

    dcache_state_t        r_state;
    logic                 r_ramREN;
    logic                 r_ramWEN;
    logic [31:0]          r_ramaddr;
    logic [31:0]          r_ramstore;
    logic [IDX_W-1:0]     r_idx;
    logic [TAG_MAX_W-1:0] r_tag;

    logic [IDX_W-1:0]     w_req_idx;
    logic [TAG_MAX_W-1:0] w_req_tag;
    dcache_frame_t        w_frame;
    dcache_frame_t        w_wframe;
    dcache_wmask_t        w_wmask;
    logic [IDX_W-1:0]     w_widx;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_dhit;
    logic                 w_miss;

    assign w_req_idx = IDX_W'(addr_index(dmemaddr, IDX_W));
    assign w_req_tag = TAG_MAX_W'(addr_tag(dmemaddr, IDX_W));
    assign w_req     = dmemREN | dmemWEN;
    assign w_hit     = w_frame.valid && (w_frame.tag == w_req_tag);
    assign w_dhit    = !RST && (r_state == IDLE) && w_req && w_hit;
    assign w_miss    = !RST && (r_state == IDLE) && w_req && !w_hit;

    assign dhit_in  = w_dhit;
    assign dmem_in  = (w_dhit && !dmemWEN) ? w_frame.data : '0;
    assign ramREN   = r_ramREN;
    assign ramWEN   = r_ramWEN;
    assign ramaddr  = r_ramaddr;
    assign ramstore = r_ramstore;

    scalar_dcache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_array (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_raddr  (w_req_idx),
        .o_rframe (w_frame),
        .i_waddr  (w_widx),
        .i_wmask  (w_wmask),
        .i_wframe (w_wframe)
    );

    // Frame update: store-hit merge, writeback clean, or fill allocate.
    always_comb begin
        w_wmask  = '0;
        w_wframe = '0;
        w_widx   = r_idx;
        if (!RST) begin
            case (r_state)
                IDLE: begin
                    if (w_dhit && dmemWEN) begin
                        w_widx         = w_req_idx;
                        w_wmask.data   = 1'b1;
                        w_wmask.dirty  = 1'b1;
                        w_wframe.data  = dmemstore;
                        w_wframe.dirty = 1'b1;
                    end
                end
                WB: begin
                    if (ram_ready) w_wmask.dirty = 1'b1;
                end
                FILL: begin
                    if (ram_ready) begin
                        w_wmask        = '1;
                        w_wframe.valid = 1'b1;
                        w_wframe.dirty = 1'b0;
                        w_wframe.tag   = r_tag;
                        w_wframe.data  = ramload;
                    end
                end
                default: ;
            endcase
        end
    end

    // Miss FSM; RAM strobes/address/data are registered here. The miss index/tag is
    // latched so a request dropped mid-miss still completes against the right frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= '0;
            r_ramstore <= '0;
            r_idx      <= '0;
            r_tag      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_idx <= w_req_idx;
                        r_tag <= w_req_tag;
                        if (w_frame.valid && w_frame.dirty) begin
                            r_state    <= WB;
                            r_ramWEN   <= 1'b1;
                            r_ramaddr  <= frame_addr(w_frame.tag, 32'(w_req_idx), IDX_W);
                            r_ramstore <= w_frame.data;
                        end else begin
                            r_state   <= FILL;
                            r_ramREN  <= 1'b1;
                            r_ramaddr <= {dmemaddr[31:2], 2'b00};
                        end
                    end
                end
                WB: begin
                    if (ram_ready) begin
                        r_state   <= FILL;
                        r_ramWEN  <= 1'b0;
                        r_ramREN  <= 1'b1;
                        r_ramaddr <= frame_addr(r_tag, 32'(r_idx), IDX_W);
                    end
                end
                FILL: begin
                    if (ram_ready) begin
                        r_state  <= IDLE;
                        r_ramREN <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SCALAR_DCACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Count completed hits and miss entries; both wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_dhit) r_hit_count  <= r_hit_count + 32'd1;
            if (w_miss) r_miss_count <= r_miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scalar_dcache.sv
// Self-checking bench for scalar_dcache: directed scenarios then randomized traffic,
// checked against an architectural memory image plus a direct-mapped hit/miss model.
// With SCALAR_DCACHE_STATS_EN defined the counters are checked as well.
module tb_scalar_dcache;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic [31:0] dmemaddr = '0;
    logic [31:0] dmemstore = '0;
    logic [31:0] dmem_in;
    logic        dhit_in;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic        ram_ready = 1'b0;
`ifdef SCALAR_DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    scalar_dcache #(.SETS(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dmem_in   (dmem_in),
        .dhit_in   (dhit_in),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ram_ready (ram_ready)
`ifdef SCALAR_DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing RAM and architectural memory image, both keyed by word address.
    logic [31:0] ram    [int unsigned];
    logic [31:0] shadow [int unsigned];

    function automatic logic [31:0] init_word(input int unsigned w);
        return w * 32'h9E37_79B1 + 32'h0000_1357;
    endfunction

    function automatic logic [31:0] ram_rd(input int unsigned w);
        return ram.exists(w) ? ram[w] : init_word(w);
    endfunction

    function automatic logic [31:0] shadow_rd(input int unsigned w);
        return shadow.exists(w) ? shadow[w] : init_word(w);
    endfunction

    // RAM responder with configurable latency and traffic log.
    int          ram_lat      = 0;
    bit          ram_lat_rand = 1'b0;
    int          ram_cycles   = 0;
    int          ram_rd_cnt   = 0;
    int          ram_wr_cnt   = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    initial begin : responder
        bit          busy;
        int          cnt;
        logic [31:0] held_addr;
        logic [31:0] held_store;
        busy = 1'b0;
        cnt = 0;
        held_addr = '0;
        held_store = '0;
        forever begin
            @(negedge CLK);
            ram_ready = 1'b0;
            if (!RST && (ramREN || ramWEN)) begin
                ram_cycles++;
                if (!busy) begin
                    busy       = 1'b1;
                    cnt        = ram_lat_rand ? int'($urandom_range(0, 3)) : ram_lat;
                    held_addr  = ramaddr;
                    held_store = ramstore;
                end else begin
                    check("ram_addr_stable", ramaddr, held_addr);
                    if (ramWEN) check("ram_store_stable", ramstore, held_store);
                end
                if (cnt == 0) begin
                    ram_ready = 1'b1;
                    busy      = 1'b0;
                    if (ramWEN) begin
                        ram[ramaddr >> 2] = ramstore;
                        ram_wr_cnt++;
                        last_wr_addr = ramaddr;
                        last_wr_data = ramstore;
                    end else begin
                        ramload = ram_rd(ramaddr >> 2);
                        ram_rd_cnt++;
                        last_rd_addr = ramaddr;
                    end
                end else begin
                    cnt--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Scoreboard: expected completions in issue order.
    typedef struct {
        bit          is_load;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: pops on every completion and checks per-cycle invariants.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                check("ram_strobe_excl", {31'b0, ramREN & ramWEN}, 32'd0);
                if (ramREN || ramWEN) check("ramaddr_align", {30'b0, ramaddr[1:0]}, 32'd0);
                if (dhit_in) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_dhit", {31'b0, dhit_in}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_load) check("load_data", dmem_in, e.data);
                    end
                end else begin
                    check("dmem_in_zero_no_hit", dmem_in, 32'd0);
                end
            end
        end
    end

    // Direct-mapped reference: which word each of the 16 frames holds.
    bit          tb_valid [16];
    bit          tb_dirty [16];
    int unsigned tb_wa    [16];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            tb_valid[i] = 1'b0;
            tb_dirty[i] = 1'b0;
            tb_wa[i]    = 0;
        end
        shadow.delete();
        foreach (ram[k]) shadow[k] = ram[k];
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Issue one request (called at posedge+#1); exp_lat < 0 means derive from RAM traffic.
    task automatic do_req(input logic [31:0] addr, input bit re, input bit we,
                          input logic [31:0] data, input bit drop_ok, input int exp_lat);
        int unsigned wa;
        int unsigned idx;
        bit          hit;
        bit          dirty_miss;
        bit          drop;
        bit          got;
        logic [31:0] vic_addr;
        logic [31:0] vic_data;
        int          c0;
        int          r0;
        int          w0;
        int          cyc;
        wa  = addr >> 2;
        idx = wa % 16;
        c0  = ram_cycles;
        r0  = ram_rd_cnt;
        w0  = ram_wr_cnt;
        cyc = 0;
        got = 1'b0;
        hit        = tb_valid[idx] && (tb_wa[idx] == wa);
        dirty_miss = !hit && tb_valid[idx] && tb_dirty[idx];
        drop       = drop_ok && !hit;
        vic_addr   = tb_wa[idx] << 2;
        vic_data   = shadow_rd(tb_wa[idx]);
        if (!hit) begin
            exp_misses++;
            tb_valid[idx] = 1'b1;
            tb_dirty[idx] = 1'b0;
            tb_wa[idx]    = wa;
        end
        if (!drop) begin
            exp_hits++;
            if (we) begin
                shadow[wa]    = data;
                tb_dirty[idx] = 1'b1;
                exp_q.push_back('{1'b0, 32'd0});
            end else begin
                exp_q.push_back('{1'b1, shadow_rd(wa)});
            end
        end
        dmemaddr  = addr;
        dmemREN   = re;
        dmemWEN   = we;
        dmemstore = data;
        if (drop) begin
            @(negedge CLK);
            @(posedge CLK);
            #1;
            dmemREN = 1'b0;
            dmemWEN = 1'b0;
            while ((ramREN || ramWEN) && cyc < 200) begin
                @(negedge CLK);
                cyc++;
            end
            check("drop_settle_timeout", 32'(cyc >= 200), 32'd0);
        end else begin
            while (!got && cyc <= 200) begin
                @(negedge CLK);
                if (dhit_in) got = 1'b1;
                else cyc++;
            end
            check("dhit_timeout", {31'b0, got}, 32'd1);
            if (exp_lat >= 0) check("latency_directed", 32'(cyc), 32'(exp_lat));
            check("latency", 32'(cyc), hit ? 32'd0 : 32'(ram_cycles - c0 + 1));
        end
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        check("ram_reads", 32'(ram_rd_cnt - r0), hit ? 32'd0 : 32'd1);
        check("ram_writes", 32'(ram_wr_cnt - w0), dirty_miss ? 32'd1 : 32'd0);
        if (!hit) check("fill_addr", last_rd_addr, wa << 2);
        if (dirty_miss) begin
            check("wb_addr", last_wr_addr, vic_addr);
            check("wb_data", last_wr_data, vic_data);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned w;
        int unsigned op;
        logic [31:0] a;
        ram[32'h10] = 32'hDEAD_BEEF;

        // Reset state.
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_dhit", {31'b0, dhit_in}, 32'd0);
        check("rst_dmem_in", dmem_in, 32'd0);
        check("rst_ramREN", {31'b0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();

        // Cold load with a slow fill.
        ram_lat = 2;
        do_req(32'h40, 1'b1, 1'b0, 32'd0, 1'b0, 4);
        check("t1_fill_addr", last_rd_addr, 32'h40);

        // Store hit, then load hit.
        do_req(32'h40, 1'b0, 1'b1, 32'h1234, 1'b0, 0);
        do_req(32'h40, 1'b1, 1'b0, 32'd0, 1'b0, 0);

        // Conflict miss on a dirty frame.
        ram_lat = 1;
        do_req(32'h80, 1'b1, 1'b0, 32'd0, 1'b0, 5);
        check("t3_wb_addr", last_wr_addr, 32'h40);
        check("t3_wb_data", last_wr_data, 32'h1234);
        check("t3_fill_addr", last_rd_addr, 32'h80);
`ifdef SCALAR_DCACHE_STATS_EN
        check("stats_hits_t3", hit_count, 32'd4);
        check("stats_misses_t3", miss_count, 32'd2);
`endif

        // Reset while a fill is outstanding.
        ram_lat  = 6;
        dmemaddr = 32'hC0;
        dmemREN  = 1'b1;
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        dmemREN = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("t4_ramREN_after_rst", {31'b0, ramREN}, 32'd0);
        check("t4_ramWEN_after_rst", {31'b0, ramWEN}, 32'd0);
        check("t4_dhit_after_rst", {31'b0, dhit_in}, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        ram_lat = 0;
        do_req(32'h40, 1'b1, 1'b0, 32'd0, 1'b0, 2);

        // Store miss with REN and WEN both high: allocate, merge, then evict dirty.
        do_req(32'h100, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 2);
        do_req(32'h100, 1'b1, 1'b0, 32'd0, 1'b0, 0);
        do_req(32'h140, 1'b1, 1'b0, 32'd0, 1'b0, 3);
        check("t5_wb_data", last_wr_data, 32'hCAFE_F00D);

        // Dropped store miss: frame allocated clean, data not merged.
        ram_lat = 2;
        do_req(32'h200, 1'b0, 1'b1, 32'h5555_AAAA, 1'b1, -1);
        do_req(32'h200, 1'b1, 1'b0, 32'd0, 1'b0, 0);

        // Randomized traffic over 64 words (4 tags per frame).
        ram_lat_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            w  = $urandom_range(0, 63);
            op = $urandom_range(0, 2);
            a  = (w << 2) | 32'($urandom_range(0, 3));
            do_req(a, op != 1, op != 0, $urandom, $urandom_range(0, 9) == 0, -1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end

        repeat (2) @(posedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef SCALAR_DCACHE_STATS_EN
        check("stats_hits_final", hit_count, 32'(exp_hits));
        check("stats_misses_final", miss_count, 32'(exp_misses));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
